timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 150 +++++++++++++++
 tb/tb_timer_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter granting timed intervals on a shared counter
//
// Purpose:
//   Arbitrates N_REQ level requesters round-robin. The winner is granted for
//   len[winner]+1 cycles while a shared counter runs from 0 up to the latched
//   length. A one-cycle DONE state then pulses done[winner], and the block
//   returns to IDLE.
//
// Optional feature (macro TIMER_ARBITER_ABORT_EN):
//   Adds input 'abort'. When abort is high in COUNT, the interval ends early.
//   Without the macro the port does not exist and intervals always run to target.
//
// Ports:
//   clk    in   1         clock, rising edge
//   rst    in   1         synchronous active-high reset
//   abort  in   1         early interval termination (only with TIMER_ARBITER_ABORT_EN)
//   req    in   N_REQ     level requests
//   len    in   N_REQ*CW  per-requester interval length, field i = len[i*CW +: CW]
//   gnt    out  N_REQ     one-hot grant, high for the whole interval
//   done   out  N_REQ     one-cycle completion pulse
//   count  out  CW        shared interval counter
//   busy   out  1         high whenever the state is not IDLE

module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef TIMER_ARBITER_ABORT_EN
  input  logic                abort,
`endif
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] len,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [CW-1:0]       count,
  output logic                busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    r_target;
  logic [CW-1:0]    w_target_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] w_done_nxt;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_last_nxt;
  logic [IW-1:0]    w_winner;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  logic             w_abort;

`ifdef TIMER_ARBITER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Round-robin search: scan from r_last+1 around to r_last itself, so the
  // most recently served requester is always considered last.
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_idx    = r_last;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = r_last + IW'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;
    w_last_nxt   = r_last;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt  = ST_COUNT;
          w_target_nxt = len[w_winner*CW +: CW];
          w_count_nxt  = '0;
          w_gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_last_nxt   = w_winner;
        end
      end
      ST_COUNT: begin
        // Counting stops at target, so the counter can never wrap.
        if (w_abort || (r_count == r_target)) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      // Last grant points at the top requester so requester 0 wins next.
      r_last   <= IW'(N_REQ - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_target <= w_target_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_last   <= w_last_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign count = r_count;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - self-checking bench for timer_arbiter

module tb_timer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  count;
  logic        busy;
`ifdef TIMER_ARBITER_ABORT_EN
  logic        abort;
`endif

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] g;
    int         w;
    int         dur;
    logic [3:0] d;
    logic [3:0] c;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] cnt_q[$];

  timer_arbiter #(.N_REQ(4), .CW(4)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef TIMER_ARBITER_ABORT_EN
    .abort(abort),
`endif
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .count(count),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant, then measures it. Returns at the cycle right
  // after the grant ends, which should be the DONE cycle.
  task automatic measure(output logic [3:0] g, output int w, output int dur,
                         output logic [3:0] d, output logic [3:0] c, output bit to);
    to = 1'b0; w = 0; dur = 0; g = '0; d = '0; c = '0;
    while (gnt === 4'b0 && w < 40) begin
      tick();
      w++;
    end
    if (gnt === 4'b0) begin
      to = 1'b1;
      return;
    end
    g = gnt;
    while (gnt === g && dur < 40) begin
      tick();
      dur++;
    end
    d = done;
    c = count;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; len = '0;
    tick(); tick();
    n_total++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b expected 0000", gnt); else n_pass++;
    n_total++; if (done !== 4'b0) $display("FAIL reset_done: got %b expected 0000", done); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] e;
    req = 4'b0001; len = 16'h0003;
    for (int i = 0; i < 4; i++) cnt_q.push_back(4'(i));
    tick();
    while (cnt_q.size() > 0) begin
      e = cnt_q.pop_front();
      n_total++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b expected 0001", gnt); else n_pass++;
      n_total++; if (count !== e) $display("FAIL single_count: got %0d expected %0d", count, e); else n_pass++;
      tick();
    end
    n_total++; if (gnt !== 4'b0) $display("FAIL single_gnt_end: got %b expected 0000", gnt); else n_pass++;
    n_total++; if (done !== 4'b0001) $display("FAIL single_done: got %b expected 0001", done); else n_pass++;
    n_total++; if (count !== 4'd3) $display("FAIL single_hold: got %0d expected 3", count); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy_done: got %b expected 1", busy); else n_pass++;
    req = '0;
    tick();
    n_total++; if (done !== 4'b0) $display("FAIL single_done_clr: got %b expected 0000", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [3:0] g, d, c;
    int w, dur;
    bit to;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; len = 16'h0000;
    exp_q.push_back('{g: 4'b0001, w: 1, dur: 1, d: 4'b0001, c: 4'd0});
    exp_q.push_back('{g: 4'b0010, w: 2, dur: 1, d: 4'b0010, c: 4'd0});
    exp_q.push_back('{g: 4'b0100, w: 2, dur: 1, d: 4'b0100, c: 4'd0});
    exp_q.push_back('{g: 4'b1000, w: 2, dur: 1, d: 4'b1000, c: 4'd0});
    exp_q.push_back('{g: 4'b0001, w: 2, dur: 1, d: 4'b0001, c: 4'd0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure(g, w, dur, d, c, to);
      n_total++; if (to !== 1'b0) $display("FAIL rr_timeout: got timeout expected grant %b", e.g); else n_pass++;
      n_total++; if (g !== e.g) $display("FAIL rr_gnt: got %b expected %b", g, e.g); else n_pass++;
      n_total++; if (w !== e.w) $display("FAIL rr_spacing: got %0d expected %0d", w, e.w); else n_pass++;
      n_total++; if (dur !== e.dur) $display("FAIL rr_dur: got %0d expected %0d", dur, e.dur); else n_pass++;
      n_total++; if (d !== e.d) $display("FAIL rr_done: got %b expected %b", d, e.d); else n_pass++;
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [3:0] g, d, c;
    int w, dur;
    bit to;
    req = 4'b0100; len = 16'h0F00;
    tick();
    for (int i = 0; i < 7; i++) tick();
    n_total++; if (count !== 4'd7) $display("FAIL rst_mid_count7: got %0d expected 7", count); else n_pass++;
    n_total++; if (gnt !== 4'b0100) $display("FAIL rst_mid_gnt: got %b expected 0100", gnt); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (gnt !== 4'b0) $display("FAIL rst_mid_gnt_clr: got %b expected 0000", gnt); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL rst_mid_count_clr: got %0d expected 0", count); else n_pass++;
    n_total++; if (done !== 4'b0) $display("FAIL rst_mid_no_done: got %b expected 0000", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else n_pass++;
    req = 4'b1111; len = 16'h0000;
    exp_q.push_back('{g: 4'b0001, w: 1, dur: 1, d: 4'b0001, c: 4'd0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure(g, w, dur, d, c, to);
      n_total++; if (to !== 1'b0) $display("FAIL rst_mid_timeout: got timeout expected grant %b", e.g); else n_pass++;
      n_total++; if (g !== e.g) $display("FAIL rst_mid_regrant: got %b expected %b", g, e.g); else n_pass++;
      n_total++; if (w !== e.w) $display("FAIL rst_mid_wait: got %0d expected %0d", w, e.w); else n_pass++;
      n_total++; if (d !== e.d) $display("FAIL rst_mid_done: got %b expected %b", d, e.d); else n_pass++;
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_len_change();
    exp_t e;
    logic [3:0] g, d, c;
    int w, dur;
    bit to;
    req = 4'b0010; len = 16'h0050;
    tick();
    len = 16'h0021; req = 4'b0011;
    exp_q.push_back('{g: 4'b0010, w: 0, dur: 6, d: 4'b0010, c: 4'd5});
    exp_q.push_back('{g: 4'b0001, w: 2, dur: 2, d: 4'b0001, c: 4'd1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure(g, w, dur, d, c, to);
      n_total++; if (to !== 1'b0) $display("FAIL lenchg_timeout: got timeout expected grant %b", e.g); else n_pass++;
      n_total++; if (g !== e.g) $display("FAIL lenchg_gnt: got %b expected %b", g, e.g); else n_pass++;
      n_total++; if (w !== e.w) $display("FAIL lenchg_wait: got %0d expected %0d", w, e.w); else n_pass++;
      n_total++; if (dur !== e.dur) $display("FAIL lenchg_dur: got %0d expected %0d", dur, e.dur); else n_pass++;
      n_total++; if (d !== e.d) $display("FAIL lenchg_done: got %b expected %b", d, e.d); else n_pass++;
      n_total++; if (c !== e.c) $display("FAIL lenchg_count: got %0d expected %0d", c, e.c); else n_pass++;
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_max_len();
    exp_t e;
    logic [3:0] g, d, c;
    int w, dur;
    bit to;
    req = 4'b1000; len = 16'hF000;
    exp_q.push_back('{g: 4'b1000, w: 1, dur: 16, d: 4'b1000, c: 4'd15});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure(g, w, dur, d, c, to);
      n_total++; if (to !== 1'b0) $display("FAIL max_timeout: got timeout expected grant %b", e.g); else n_pass++;
      n_total++; if (g !== e.g) $display("FAIL max_gnt: got %b expected %b", g, e.g); else n_pass++;
      n_total++; if (dur !== e.dur) $display("FAIL max_dur: got %0d expected %0d", dur, e.dur); else n_pass++;
      n_total++; if (d !== e.d) $display("FAIL max_done: got %b expected %b", d, e.d); else n_pass++;
      n_total++; if (c !== e.c) $display("FAIL max_count: got %0d expected %0d", c, e.c); else n_pass++;
    end
    req = '0;
    tick();
    n_total++; if (count !== 4'd15) $display("FAIL max_idle_hold: got %0d expected 15", count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL max_idle_busy: got %b expected 0", busy); else n_pass++;
    tick();
  endtask

`ifdef TIMER_ARBITER_ABORT_EN
  task automatic test_abort();
    req = 4'b0001; len = 16'h000A;
    tick();
    for (int i = 0; i < 4; i++) tick();
    n_total++; if (count !== 4'd4) $display("FAIL abort_count4: got %0d expected 4", count); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if (done !== 4'b0001) $display("FAIL abort_done: got %b expected 0001", done); else n_pass++;
    n_total++; if (gnt !== 4'b0) $display("FAIL abort_gnt: got %b expected 0000", gnt); else n_pass++;
    n_total++; if (count !== 4'd4) $display("FAIL abort_hold: got %0d expected 4", count); else n_pass++;
    req = '0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_idle_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 4'b0) $display("FAIL abort_idle_done: got %b expected 0000", done); else n_pass++;
    n_total++; if (count !== 4'd4) $display("FAIL abort_idle_count: got %0d expected 4", count); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; len = '0;
`ifdef TIMER_ARBITER_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_reset_mid();
    test_len_change();
    test_max_len();
`ifdef TIMER_ARBITER_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
